// File: rtl/eq_pkg.sv
// Shared types, coefficient map and saturation helper for the equalizer blocks.
package eq_pkg;

  typedef logic signed [15:0] sample_t;
  typedef logic [4:0]         coef_idx_t;

  localparam coef_idx_t B0_OFS         = 5'd0;
  localparam coef_idx_t B1_OFS         = 5'd1;
  localparam coef_idx_t B2_OFS         = 5'd2;
  localparam coef_idx_t A1_OFS         = 5'd3;
  localparam coef_idx_t A2_OFS         = 5'd4;
  localparam coef_idx_t COEFS_PER_BAND = 5'd5;
  localparam coef_idx_t GAIN_BASE      = 5'd15;
  localparam coef_idx_t NUM_COEF       = 5'd18;
  localparam int        NUM_BANDS      = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_e;

  function automatic sample_t sat16(input logic signed [63:0] v);
    if (v > 64'sh7FFF) return 16'sh7FFF;
    if (v < -64'sh8000) return 16'sh8000;
    return sample_t'(v[15:0]);
  endfunction

endpackage

// File: rtl/eq_lrclk_sync.sv
// Brings the asynchronous sample clock into the clk domain and flags its rising edge.
module eq_lrclk_sync (
  input  logic clk,
  input  logic reset,
  input  logic l_r_clk,
  output logic edge_pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;

  always_comb begin
    sync1_d = l_r_clk;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign edge_pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/eq_mac_sequencer.sv
// Three-band biquad equalizer plus gain mix on one shared MAC, one pass per sample edge.
// Define EQ_BAND_PROBE_EN to expose the per-band results as extra output ports.
module eq_mac_sequencer
  import eq_pkg::*;
#(
  parameter int ACC_W     = 40,
  parameter int COEF_BASE = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        l_r_clk,
  input  logic [15:0] audio_in,
  input  logic [15:0] coef_data,
  output logic [4:0]  coef_addr,
  output logic [15:0] audio_out,
  output logic        out_valid,
  output logic        busy,
  output logic        overrun
`ifdef EQ_BAND_PROBE_EN
  ,
  output logic [15:0] low_band_out,
  output logic [15:0] mid_band_out,
  output logic [15:0] high_band_out
`endif
);

  logic edge_pulse;

  eq_lrclk_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .l_r_clk    (l_r_clk),
    .edge_pulse (edge_pulse)
  );

  state_e                   state_q, state_d;
  coef_idx_t                cnt_q, cnt_d;
  coef_idx_t                coef_addr_q, coef_addr_d;
  logic                     acc_valid_q, acc_valid_d;
  coef_idx_t                acc_idx_q, acc_idx_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  sample_t                  x0_q, x0_d, x1_q, x1_d, x2_q, x2_d;
  sample_t                  y1_q [NUM_BANDS];
  sample_t                  y1_d [NUM_BANDS];
  sample_t                  y2_q [NUM_BANDS];
  sample_t                  y2_d [NUM_BANDS];
  sample_t                  audio_out_q, audio_out_d;
  logic                     out_valid_q, out_valid_d;
  logic                     overrun_q, overrun_d;

  logic                     is_gain, is_load, is_sub;
  logic [1:0]               band;
  coef_idx_t                band_base, ofs;
  sample_t                  operand;
  logic signed [31:0]       prod;
  logic signed [ACC_W-1:0]  term, acc_base, acc_sum;

  // Sequencer: coef_addr is registered, so the address for cnt is set up one cycle early.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    coef_addr_d = coef_addr_q;
    acc_valid_d = 1'b0;
    acc_idx_d   = acc_idx_q;
    x0_d        = x0_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    audio_out_d = audio_out_q;
    out_valid_d = 1'b0;
    overrun_d   = overrun_q | (edge_pulse && (state_q != ST_IDLE));
    case (state_q)
      ST_IDLE: begin
        if (edge_pulse) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        x0_d        = sample_t'(audio_in);
        cnt_d       = 5'd0;
        coef_addr_d = 5'(COEF_BASE);
        state_d     = ST_ISSUE;
      end
      ST_ISSUE: begin
        acc_valid_d = 1'b1;
        acc_idx_d   = cnt_q;
        if (cnt_q == NUM_COEF - 5'd1) begin
          state_d = ST_DRAIN;
        end else begin
          cnt_d       = cnt_q + 5'd1;
          coef_addr_d = cnt_q + 5'd1 + 5'(COEF_BASE);
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        audio_out_d = sat16(64'(acc_q >>> 14));
        out_valid_d = 1'b1;
        x2_d        = x1_q;
        x1_d        = x0_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // MAC: acc_idx_q names the coefficient arriving on coef_data this cycle.
  always_comb begin
    acc_d = acc_q;
    y1_d  = y1_q;
    y2_d  = y2_q;
    is_gain   = (acc_idx_q >= GAIN_BASE);
    band      = 2'd0;
    band_base = 5'd0;
    if (is_gain) begin
      band      = 2'(acc_idx_q - GAIN_BASE);
      band_base = GAIN_BASE;
    end else if (acc_idx_q >= 5'd2 * COEFS_PER_BAND) begin
      band      = 2'd2;
      band_base = 5'd2 * COEFS_PER_BAND;
    end else if (acc_idx_q >= COEFS_PER_BAND) begin
      band      = 2'd1;
      band_base = COEFS_PER_BAND;
    end
    ofs     = acc_idx_q - band_base;
    operand = 16'sd0;
    if (is_gain) begin
      operand = y1_q[band];
    end else begin
      case (ofs)
        B0_OFS:  operand = x0_q;
        B1_OFS:  operand = x1_q;
        B2_OFS:  operand = x2_q;
        A1_OFS:  operand = y1_q[band];
        A2_OFS:  operand = y2_q[band];
        default: operand = 16'sd0;
      endcase
    end
    prod     = 32'(signed'(coef_data)) * 32'(operand);
    is_sub   = !is_gain && ((ofs == A1_OFS) || (ofs == A2_OFS));
    term     = is_sub ? -ACC_W'(prod) : ACC_W'(prod);
    is_load  = (ofs == B0_OFS);
    acc_base = is_load ? {ACC_W{1'b0}} : acc_q;
    acc_sum  = acc_base + term;
    if (acc_valid_q) begin
      acc_d = acc_sum;
      if (!is_gain && (ofs == A2_OFS)) begin
        y2_d[band] = y1_q[band];
        y1_d[band] = sat16(64'(acc_sum >>> 14));
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 5'd0;
      coef_addr_q <= 5'd0;
      acc_valid_q <= 1'b0;
      acc_idx_q   <= 5'd0;
      acc_q       <= '0;
      x0_q        <= 16'sd0;
      x1_q        <= 16'sd0;
      x2_q        <= 16'sd0;
      y1_q        <= '{default: 16'sd0};
      y2_q        <= '{default: 16'sd0};
      audio_out_q <= 16'sd0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      coef_addr_q <= coef_addr_d;
      acc_valid_q <= acc_valid_d;
      acc_idx_q   <= acc_idx_d;
      acc_q       <= acc_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      y1_q        <= y1_d;
      y2_q        <= y2_d;
      audio_out_q <= audio_out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign coef_addr = coef_addr_q;
  assign audio_out = audio_out_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign overrun   = overrun_q;

`ifdef EQ_BAND_PROBE_EN
  assign low_band_out  = y1_q[0];
  assign mid_band_out  = y1_q[1];
  assign high_band_out = y1_q[2];
`endif

endmodule

// File: tb/tb_eq_mac_sequencer.sv
// Directed scoreboard bench for eq_mac_sequencer with a synchronous coefficient store model.
module tb_eq_mac_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        l_r_clk;
  logic [15:0] audio_in;
  logic [15:0] coef_data;
  logic [4:0]  coef_addr;
  logic [15:0] audio_out;
  logic        out_valid;
  logic        busy;
  logic        overrun;

  logic [15:0] coef_mem [0:17];
  logic [15:0] sb [$];
  int          compared    = 0;
  int          mismatched  = 0;
  int          valid_count = 0;
  int          v0;

  always #5 clk = ~clk;

  eq_mac_sequencer #(.ACC_W(40), .COEF_BASE(0)) dut (
    .clk       (clk),
    .reset     (reset),
    .l_r_clk   (l_r_clk),
    .audio_in  (audio_in),
    .coef_data (coef_data),
    .coef_addr (coef_addr),
    .audio_out (audio_out),
    .out_valid (out_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  // Coefficient store: data appears the cycle after the address.
  always @(posedge clk)
    coef_data <= (coef_addr < 5'd18) ? coef_mem[coef_addr] : 16'h0000;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Scoreboard consumer: every out_valid pulse pops one expected sample.
  always @(negedge clk) begin
    if (reset === 1'b1 && out_valid === 1'b1) begin
      valid_count++;
      check_output("queue_has_entry", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) check_output("audio_out", 32'(audio_out), 32'(sb.pop_front()));
    end
  end

  task automatic clear_coefs();
    for (int i = 0; i < 18; i++) coef_mem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    l_r_clk = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [15:0] x, input logic [15:0] expected);
    audio_in = x;
    sb.push_back(expected);
    @(negedge clk) l_r_clk = 1'b1;
    repeat (4) @(negedge clk);
    l_r_clk = 1'b0;
    repeat (30) @(negedge clk);
    check_output("output_arrived", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset    = 1'b0;
    l_r_clk  = 1'b0;
    audio_in = 16'h0000;
    clear_coefs();
    repeat (2) @(negedge clk);
    check_output("rst_audio_out", 32'(audio_out), 32'h0);
    check_output("rst_coef_addr", 32'(coef_addr), 32'h0);
    check_output("rst_out_valid", 32'(out_valid), 32'h0);
    check_output("rst_busy", 32'(busy), 32'h0);
    check_output("rst_overrun", 32'(overrun), 32'h0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] passthrough with latency check");
    coef_mem[0]  = 16'h4000;
    coef_mem[15] = 16'h4000;
    audio_in = 16'h2000;
    sb.push_back(16'h2000);
    @(negedge clk) l_r_clk = 1'b1;
    repeat (23) @(posedge clk);
    #1 check_output("valid_before_22", 32'(out_valid), 32'h0);
    check_output("busy_mid_sample", 32'(busy), 32'h1);
    @(posedge clk);
    #1 check_output("valid_at_22", 32'(out_valid), 32'h1);
    check_output("pass_audio_out", 32'(audio_out), 32'h2000);
    @(posedge clk);
    #1 check_output("valid_one_cycle", 32'(out_valid), 32'h0);
    check_output("busy_after_done", 32'(busy), 32'h0);
    check_output("coef_addr_held", 32'(coef_addr), 32'd17);
    @(negedge clk) l_r_clk = 1'b0;
    repeat (10) @(negedge clk);
    check_output("pass_arrived", 32'(sb.size()), 32'd0);

    $display("[TB] delay through band1 b1");
    do_reset();
    clear_coefs();
    coef_mem[6]  = 16'h4000;
    coef_mem[16] = 16'h4000;
    apply_stimulus(16'h4000, 16'h0000);
    apply_stimulus(16'h0000, 16'h4000);
    apply_stimulus(16'h0000, 16'h0000);

    $display("[TB] feedback through band2 a1");
    do_reset();
    clear_coefs();
    coef_mem[10] = 16'h4000;
    coef_mem[13] = 16'hE000;
    coef_mem[17] = 16'h4000;
    apply_stimulus(16'h4000, 16'h4000);
    apply_stimulus(16'h0000, 16'h2000);
    apply_stimulus(16'h0000, 16'h1000);
    apply_stimulus(16'h0000, 16'h0800);

    $display("[TB] saturation");
    do_reset();
    clear_coefs();
    coef_mem[0]  = 16'h7FFF;
    coef_mem[5]  = 16'h7FFF;
    coef_mem[10] = 16'h7FFF;
    coef_mem[15] = 16'h7FFF;
    coef_mem[16] = 16'h7FFF;
    coef_mem[17] = 16'h7FFF;
    apply_stimulus(16'h7FFF, 16'h7FFF);
    apply_stimulus(16'h8000, 16'h8000);

    $display("[TB] overrun");
    do_reset();
    clear_coefs();
    coef_mem[0]  = 16'h4000;
    coef_mem[15] = 16'h4000;
    audio_in = 16'h1000;
    sb.push_back(16'h1000);
    v0 = valid_count;
    @(negedge clk) l_r_clk = 1'b1;
    repeat (4) @(negedge clk);
    l_r_clk = 1'b0;
    repeat (6) @(negedge clk);
    l_r_clk = 1'b1;
    repeat (4) @(negedge clk);
    l_r_clk = 1'b0;
    repeat (30) @(negedge clk);
    check_output("overrun_set", 32'(overrun), 32'h1);
    check_output("single_valid", 32'(valid_count - v0), 32'd1);
    check_output("overrun_arrived", 32'(sb.size()), 32'd0);
    apply_stimulus(16'h0C00, 16'h0C00);
    check_output("overrun_sticky", 32'(overrun), 32'h1);

    $display("[TB] reset during ISSUE");
    audio_in = 16'h3000;
    @(negedge clk) l_r_clk = 1'b1;
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    l_r_clk = 1'b0;
    #1 check_output("midrst_audio_out", 32'(audio_out), 32'h0);
    check_output("midrst_coef_addr", 32'(coef_addr), 32'h0);
    check_output("midrst_out_valid", 32'(out_valid), 32'h0);
    check_output("midrst_busy", 32'(busy), 32'h0);
    check_output("midrst_overrun", 32'(overrun), 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    apply_stimulus(16'h2000, 16'h2000);
    check_output("post_rst_overrun", 32'(overrun), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/eq_mac_sequencer.md
# eq_mac_sequencer

Time-multiplexed controller for the three-band equalizer: on every left/right-clock rising edge it runs all three biquad bands (low, mid, high) and the final gain mix through one shared multiplier-accumulator. Coefficients come from an external synchronous coefficient store. The block sits between the I2S sample interface and the codec output and replaces three parallel filter datapaths.

## Interface
- ACC_W, 40, accumulator width in bits (≥ 36)
- COEF_BASE, 0, address offset added to every coef_addr
- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-low reset
- l_r_clk  in  1  sample clock (48 kHz), asynchronous to clk
- audio_in  in  16  signed Q2.14 input sample
- coef_data  in  16  signed Q2.14 coefficient; valid the clk cycle after coef_addr
- coef_addr  out  5  coefficient index + COEF_BASE
- audio_out  out  16  signed Q2.14 equalized sample, held between updates
- out_valid  out  1  one-cycle pulse when audio_out updates
- busy  out  1  high whenever state ≠ IDLE
- overrun  out  1  sticky; set when a sample edge is dropped

## Operation
- Coefficient map, per band k = 0..2 (low, mid, high): index 5k+0..4 = b0, b1, b2, a1, a2. Indices 15..17 = gain_k.
- Band equation: y_k = b0·x0 + b1·x1 + b2·x2 − a1·y_k1 − a2·y_k2. x history is shared across bands; y history is per band.
- Products: 16×16 → 32-bit Q4.28, sign-extended to ACC_W. a-terms are subtracted.
- Band result: acc >>> 14, saturated to [0x8000, 0x7FFF]. It is stored in y_k, and y_k2 ← y_k1, y_k1 ← y_k.
- Mix: audio_out = sat16((Σ gain_k·y_k) >>> 14). The mix uses the new y_k values.
- After the mix: x2 ← x1, x1 ← x0.
- FSM states and transitions:
  - IDLE → CAPTURE on edge_pulse. CAPTURE latches audio_in into x0.
  - CAPTURE → ISSUE with cnt=0. ISSUE drives coef_addr = cnt for cnt = 0..17, then goes to DRAIN.
  - DRAIN → DONE → IDLE.
- Accumulation: happens the cycle after each address. The first accumulate of each band (indices 0, 5, 10) and of the mix (index 15) loads the accumulator instead of adding. Band write-back happens on the accumulate of index 5k+4.
- Overrun: an edge_pulse in any state other than IDLE sets overrun and drops that sample. The sequence in progress completes normally. overrun clears only on reset.
- Reset (asynchronous, any state, including mid-ISSUE):
  - state IDLE; all histories and the accumulator cleared.
  - audio_out=0, coef_addr=0, out_valid=0, busy=0, overrun=0.

## Timing
- l_r_clk passes through a 2-FF synchronizer plus an edge register. edge_pulse is one clk cycle wide.
- Cycle numbering, with edge_pulse at cycle E:
  - CAPTURE at E+1
  - ISSUE at E+2..E+19
  - DRAIN at E+20 (last accumulate)
  - DONE at E+21 (audio_out registered)
  - out_valid high at E+22
- Total latency from edge_pulse to out_valid is 22 clk cycles, well inside the ~2083-cycle sample budget.
- coef_addr is registered and holds its last value outside ISSUE.
- An edge at E+1..E+21 counts as overrun. An edge at E+22 or later is accepted.

## Configuration
- EQ_BAND_PROBE_EN defined: adds output ports low_band_out, mid_band_out, high_band_out (16 bits each, signed Q2.14). Each equals the latest saturated y_k, updates at its band's write-back and resets to 0.
- EQ_BAND_PROBE_EN undefined: those ports and their registers do not exist. All other behaviour and timing is identical.

## Structure
- Package eq_pkg holds:
  - sample_t (signed 16-bit)
  - coefficient index constants (B0_OFS..A2_OFS, GAIN_BASE=15, NUM_COEF=18)
  - FSM state enum
  - the sat16 function shared with the other filter blocks
- Sub-module eq_lrclk_sync contains the synchronizer and rising-edge detector. It outputs edge_pulse.

## Test plan
- Reset asserted mid-ISSUE → all outputs 0 immediately. The next sample, run with passthrough coefficients, matches the result from a fresh reset.
- Passthrough (band0 b0=0x4000, gain0=0x4000, all else 0), audio_in=0x2000 → audio_out=0x2000 and out_valid exactly 22 cycles after edge_pulse.
- Delay test (band1 b1=0x4000, gain1=0x4000), impulse 0x4000 then zeros → audio_out reads 0x0000, 0x4000, 0x0000 on successive samples.
- Feedback test (band2 b0=0x4000, a1=0xE000, gain2=0x4000), impulse 0x4000 → audio_out reads 0x4000, 0x2000, 0x1000, 0x0800.
- Saturation test (b0=0x7FFF in all bands, all gains 0x7FFF), audio_in=0x7FFF → audio_out=0x7FFF. audio_in=0x8000 → audio_out=0x8000.
- Overrun test: second l_r_clk edge 10 cycles after edge_pulse → overrun=1 and remains set, exactly one out_valid is produced, and the next regular edge is processed normally.
